// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-access controller.
package spi_reg_pkg;

    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned CMD_RD_BIT = 7;

    // Byte presented to the shifter whenever no read data is pending.
    localparam logic [DATA_W-1:0] IDLE_TX = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        RD_FETCH,
        READ
    } state_t;

    // Register addresses wrap modulo 2**ADDR_W.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-interface and register-bus signals of the SPI register controller.
interface spi_reg_ctrl_if;
    import spi_reg_pkg::*;

    logic                  SS;
    logic                  rxValid;
    logic [DATA_W-1:0]     rx;
    logic [DATA_W-1:0]     tx;
    logic [ADDR_W-1:0]     reg_addr;
    logic [DATA_W-1:0]     reg_wdata;
    logic                  reg_we;
    logic                  reg_re;
    logic [DATA_W-1:0]     reg_rdata;
    logic                  frame_active;
    logic [CNT_W-1:0]      frame_bytes;

    // Controller side: owns the register bus and the tx byte.
    modport master (
        input  SS,
        input  rxValid,
        input  rx,
        input  reg_rdata,
        output tx,
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output reg_re,
        output frame_active,
        output frame_bytes
    );

    // Environment side: byte interface plus register bank.
    modport slave (
        output SS,
        output rxValid,
        output rx,
        output reg_rdata,
        input  tx,
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  reg_re,
        input  frame_active,
        input  frame_bytes
    );

endinterface

// File: rtl/spi_sync2.sv
// Two-flop synchronizer for a level crossing into the system clock domain.
// Resets to 1 so an idle (high) slave select is seen from the start.
module spi_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Metastability filter: two back-to-back flops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI register-access controller: frames the byte stream by slave select,
// decodes the command byte and drives an auto-incrementing register bus.
module spi_reg_ctrl
    import spi_reg_pkg::*;
(
    input  logic           sysClk,
    input  logic           usrReset,
    spi_reg_ctrl_if.master bus
);

    logic                  w_ss_s;
    logic                  w_cmd_rd;
    logic [ADDR_W-1:0]     w_cmd_addr;
    logic                  w_frame_start;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_addr;
    logic [ADDR_W-1:0]     w_addr_nxt;
    logic [DATA_W-1:0]     r_tx;
    logic [DATA_W-1:0]     w_tx_nxt;
    logic [ADDR_W-1:0]     r_reg_addr;
    logic [ADDR_W-1:0]     w_reg_addr_nxt;
    logic [DATA_W-1:0]     r_reg_wdata;
    logic [DATA_W-1:0]     w_reg_wdata_nxt;
    logic                  r_reg_we;
    logic                  w_reg_we_nxt;
    logic                  r_reg_re;
    logic                  w_reg_re_nxt;
    logic                  r_frame_active;
    logic [CNT_W-1:0]      r_frame_bytes;
    logic [CNT_W-1:0]      w_frame_bytes_nxt;

    spi_sync2 u_ss_sync (
        .i_clk (sysClk),
        .i_rst (usrReset),
        .i_d   (bus.SS),
        .o_q   (w_ss_s)
    );

    assign w_cmd_rd      = bus.rx[CMD_RD_BIT];
    assign w_cmd_addr    = bus.rx[ADDR_W-1:0];
    assign w_frame_start = (r_state == IDLE) && !w_ss_s;

    // State register.
    always_ff @(posedge sysClk or posedge usrReset) begin
        if (usrReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, address counter and bus strobes.
    // A byte arriving in the cycle slave select rises is still processed;
    // the forced return to IDLE below only overrides the next state.
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_tx_nxt        = r_tx;
        w_reg_addr_nxt  = r_reg_addr;
        w_reg_wdata_nxt = r_reg_wdata;
        w_reg_we_nxt    = 1'b0;
        w_reg_re_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_ss_s) begin
                    w_state_nxt = CMD;
                end
            end
            CMD: begin
                if (bus.rxValid) begin
                    w_addr_nxt = w_cmd_addr;
                    if (w_cmd_rd) begin
                        w_reg_addr_nxt = w_cmd_addr;
                        w_reg_re_nxt   = 1'b1;
                        w_state_nxt    = RD_FETCH;
                    end else begin
                        w_state_nxt    = WRITE;
                    end
                end
            end
            WRITE: begin
                if (bus.rxValid) begin
                    w_reg_addr_nxt  = r_addr;
                    w_reg_wdata_nxt = bus.rx;
                    w_reg_we_nxt    = 1'b1;
                    w_addr_nxt      = addr_inc(r_addr);
                end
            end
            RD_FETCH: begin
                // Read data is valid the cycle after the strobe has dropped.
                if (!r_reg_re) begin
                    w_tx_nxt    = bus.reg_rdata;
                    w_state_nxt = READ;
                end
            end
            READ: begin
                if (bus.rxValid) begin
                    w_addr_nxt     = addr_inc(r_addr);
                    w_reg_addr_nxt = addr_inc(r_addr);
                    w_reg_re_nxt   = 1'b1;
                    w_state_nxt    = RD_FETCH;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if ((r_state != IDLE) && w_ss_s) begin
            w_state_nxt = IDLE;
        end

        // Only a completed fetch may put data on tx; everything else idles.
        if ((w_state_nxt == IDLE) || (w_state_nxt == CMD) || (w_state_nxt == WRITE)) begin
            w_tx_nxt = IDLE_TX;
        end
    end

    // Frame byte counter: cleared at frame start, saturating at all-ones.
    always_comb begin
        w_frame_bytes_nxt = r_frame_bytes;
        if (w_frame_start) begin
            w_frame_bytes_nxt = '0;
        end else if (bus.rxValid && !w_ss_s && (r_frame_bytes != '1)) begin
            w_frame_bytes_nxt = r_frame_bytes + CNT_W'(1);
        end
    end

    // Output and datapath registers.
    always_ff @(posedge sysClk or posedge usrReset) begin
        if (usrReset) begin
            r_addr         <= '0;
            r_tx           <= IDLE_TX;
            r_reg_addr     <= '0;
            r_reg_wdata    <= '0;
            r_reg_we       <= 1'b0;
            r_reg_re       <= 1'b0;
            r_frame_active <= 1'b0;
            r_frame_bytes  <= '0;
        end else begin
            r_addr         <= w_addr_nxt;
            r_tx           <= w_tx_nxt;
            r_reg_addr     <= w_reg_addr_nxt;
            r_reg_wdata    <= w_reg_wdata_nxt;
            r_reg_we       <= w_reg_we_nxt;
            r_reg_re       <= w_reg_re_nxt;
            r_frame_active <= !w_ss_s;
            r_frame_bytes  <= w_frame_bytes_nxt;
        end
    end

    assign bus.tx           = r_tx;
    assign bus.reg_addr     = r_reg_addr;
    assign bus.reg_wdata    = r_reg_wdata;
    assign bus.reg_we       = r_reg_we;
    assign bus.reg_re       = r_reg_re;
    assign bus.frame_active = r_frame_active;
    assign bus.frame_bytes  = r_frame_bytes;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: table of frames, hand-written corner
// sequences and random frames against a transaction-level reference model.
module tb_spi_reg_ctrl;
    import spi_reg_pkg::*;

    localparam int GAP = 6;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [3:0][7:0] bytes;
        int              n;
        int              exp_we;
        int              exp_re;
        int              exp_fb;
        logic [6:0]      exp_last;
        logic [7:0]      exp_tx;
    } vec_t;

    logic sysClk;
    logic usrReset;
    logic bank_load;

    spi_reg_ctrl_if bus ();

    spi_reg_ctrl dut (
        .sysClk   (sysClk),
        .usrReset (usrReset),
        .bus      (bus)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    logic [7:0] bank    [128];
    logic [7:0] ref_mem [128];
    wr_t        q_we [$];
    logic [6:0] q_re [$];
    int         both_cnt = 0;
    logic [7:0] frame_q [$];
    int         checks = 0;
    int         errors = 0;
    vec_t       tbl [6];
    logic [6:0] la;
    logic [7:0] lt;

    function automatic logic [7:0] init_val(input int i);
        case (i)
            'h7E:    return 8'h3C;
            'h7F:    return 8'h4D;
            'h00:    return 8'h5E;
            'h01:    return 8'h6F;
            default: return 8'((i * 7 + 3) & 255);
        endcase
    endfunction

    // Register bank responder and bus monitor.
    always @(posedge sysClk) begin
        if (bank_load) begin
            for (int i = 0; i < 128; i++) bank[i] <= init_val(i);
        end else if (bus.reg_we) begin
            bank[bus.reg_addr] <= bus.reg_wdata;
        end
        if (bus.reg_re) bus.reg_rdata <= bank[bus.reg_addr];
        if (bus.reg_we) q_we.push_back({bus.reg_addr, bus.reg_wdata});
        if (bus.reg_re) q_re.push_back(bus.reg_addr);
        if (bus.reg_we && bus.reg_re) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic start_frame();
        bus.SS = 1'b0;
        repeat (4) tick();
    endtask

    task automatic end_frame();
        bus.SS = 1'b1;
        repeat (5) tick();
    endtask

    // One byte from the shifter; checks strobe at T+1 and tx at T+2/T+3.
    task automatic send_byte(input logic [7:0] b, input logic [7:0] tx_old,
                             input logic [7:0] tx_new, input logic ew, input logic er);
        bus.rxValid = 1'b1;
        bus.rx      = b;
        tick();
        bus.rxValid = 1'b0;
        chk("strobe", 32'({bus.reg_we, bus.reg_re}), 32'({ew, er}));
        tick();
        chk("tx_before", 32'(bus.tx), 32'(tx_old));
        tick();
        chk("tx_after", 32'(bus.tx), 32'(tx_new));
        repeat (GAP - 3) tick();
    endtask

    // Runs frame_q as one frame and checks it against the reference model.
    task automatic run_frame(output logic [6:0] last_addr, output logic [7:0] last_tx);
        wr_t        exp_we [$];
        logic [6:0] exp_re [$];
        int         n, bw, br, bb, bad, fb_exp;
        logic [7:0] cmd, prev, nxt;
        logic [6:0] ak;
        n    = frame_q.size();
        cmd  = frame_q[0];
        prev = IDLE_TX;
        bw   = q_we.size();
        br   = q_re.size();
        bb   = both_cnt;
        start_frame();
        for (int k = 0; k < n; k++) begin
            if (cmd[7]) begin
                ak  = 7'((int'(cmd[6:0]) + k) % 128);
                nxt = ref_mem[ak];
                exp_re.push_back(ak);
                send_byte(frame_q[k], prev, nxt, 1'b0, 1'b1);
                prev = nxt;
            end else if (k == 0) begin
                send_byte(frame_q[k], IDLE_TX, IDLE_TX, 1'b0, 1'b0);
            end else begin
                ak = 7'((int'(cmd[6:0]) + k - 1) % 128);
                exp_we.push_back({ak, frame_q[k]});
                ref_mem[ak] = frame_q[k];
                send_byte(frame_q[k], IDLE_TX, IDLE_TX, 1'b1, 1'b0);
            end
        end
        last_tx = bus.tx;
        end_frame();
        chk("we_count", 32'(q_we.size() - bw), 32'(exp_we.size()));
        bad = 0;
        for (int i = 0; i < exp_we.size() && bw + i < q_we.size(); i++)
            if (q_we[bw + i] !== exp_we[i]) bad++;
        chk("we_content", 32'(bad), 32'(0));
        chk("re_count", 32'(q_re.size() - br), 32'(exp_re.size()));
        bad = 0;
        for (int i = 0; i < exp_re.size() && br + i < q_re.size(); i++)
            if (q_re[br + i] !== exp_re[i]) bad++;
        chk("re_content", 32'(bad), 32'(0));
        fb_exp = (n > 255) ? 255 : n;
        chk("frame_bytes", 32'(bus.frame_bytes), 32'(fb_exp));
        chk("end_tx", 32'(bus.tx), 32'(IDLE_TX));
        chk("end_active", 32'(bus.frame_active), 32'(0));
        chk("we_re_overlap", 32'(both_cnt - bb), 32'(0));
        last_addr = '0;
        if (cmd[7] && q_re.size() > br) last_addr = q_re[q_re.size() - 1];
        else if (!cmd[7] && q_we.size() > bw) last_addr = q_we[q_we.size() - 1].addr;
    endtask

    initial begin
        int bw, br, bad, n;

        usrReset    = 1'b1;
        bank_load   = 1'b1;
        bus.SS      = 1'b1;
        bus.rxValid = 1'b0;
        bus.rx      = 8'h00;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);

        tbl[0] = '{{8'h33, 8'h22, 8'h11, 8'h05}, 4, 3, 0, 4, 7'h07, 8'hA5};
        tbl[1] = '{{8'h00, 8'h00, 8'h00, 8'hFE}, 4, 0, 4, 4, 7'h01, 8'h6F};
        tbl[2] = '{{8'h00, 8'hBB, 8'hAA, 8'h7F}, 3, 2, 0, 3, 7'h00, 8'hA5};
        tbl[3] = '{{8'h00, 8'h00, 8'h00, 8'hFF}, 2, 0, 2, 2, 7'h00, 8'hBB};
        tbl[4] = '{{8'h00, 8'h00, 8'h00, 8'h80}, 1, 0, 1, 1, 7'h00, 8'hBB};
        tbl[5] = '{{8'h00, 8'h00, 8'h77, 8'h10}, 2, 1, 0, 2, 7'h10, 8'hA5};

        // Reset values, during and after reset.
        repeat (3) tick();
        bank_load = 1'b0;
        chk("rst_tx", 32'(bus.tx), 32'(8'hA5));
        chk("rst_addr", 32'(bus.reg_addr), 32'(0));
        chk("rst_wdata", 32'(bus.reg_wdata), 32'(0));
        chk("rst_we", 32'(bus.reg_we), 32'(0));
        chk("rst_re", 32'(bus.reg_re), 32'(0));
        chk("rst_active", 32'(bus.frame_active), 32'(0));
        chk("rst_fb", 32'(bus.frame_bytes), 32'(0));
        usrReset = 1'b0;
        repeat (3) tick();
        chk("post_rst_tx", 32'(bus.tx), 32'(8'hA5));
        chk("post_rst_active", 32'(bus.frame_active), 32'(0));

        // Table of frames.
        for (int t = 0; t < 6; t++) begin
            frame_q.delete();
            for (int j = 0; j < tbl[t].n; j++) frame_q.push_back(tbl[t].bytes[j]);
            bw = q_we.size();
            br = q_re.size();
            run_frame(la, lt);
            chk($sformatf("tbl%0d_we", t), 32'(q_we.size() - bw), 32'(tbl[t].exp_we));
            chk($sformatf("tbl%0d_re", t), 32'(q_re.size() - br), 32'(tbl[t].exp_re));
            chk($sformatf("tbl%0d_fb", t), 32'(bus.frame_bytes), 32'(tbl[t].exp_fb));
            chk($sformatf("tbl%0d_last_addr", t), 32'(la), 32'(tbl[t].exp_last));
            chk($sformatf("tbl%0d_tx", t), 32'(lt), 32'(tbl[t].exp_tx));
        end

        // frame_active latency and frame_bytes clear on frame start.
        bus.SS = 1'b0;
        tick();
        tick();
        chk("active_at_2", 32'(bus.frame_active), 32'(0));
        tick();
        chk("active_at_3", 32'(bus.frame_active), 32'(1));
        chk("fb_cleared", 32'(bus.frame_bytes), 32'(0));
        end_frame();

        // Abort: SS rises with the read command, fetch discarded.
        bus.SS = 1'b0;
        repeat (4) tick();
        bw = q_we.size();
        br = q_re.size();
        bus.rxValid = 1'b1;
        bus.rx      = 8'hA0;
        bus.SS      = 1'b1;
        tick();
        bus.rxValid = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.tx !== 8'hA5) bad++;
            tick();
        end
        chk("abort_tx_idle", 32'(bad), 32'(0));
        chk("abort_active", 32'(bus.frame_active), 32'(0));
        chk("abort_re_count", 32'(q_re.size() - br), 32'(1));
        if (q_re.size() > br) chk("abort_re_addr", 32'(q_re[br]), 32'(7'h20));
        chk("abort_we_count", 32'(q_we.size() - bw), 32'(0));
        frame_q.delete();
        frame_q.push_back(8'h10);
        frame_q.push_back(8'h99);
        run_frame(la, lt);
        chk("abort_next_addr", 32'(la), 32'(7'h10));

        // Last write byte coincides with rising synchronized SS.
        bus.SS = 1'b0;
        repeat (4) tick();
        bw = q_we.size();
        send_byte(8'h30, 8'hA5, 8'hA5, 1'b0, 1'b0);
        send_byte(8'h01, 8'hA5, 8'hA5, 1'b1, 1'b0);
        bus.SS = 1'b1;
        tick();
        tick();
        bus.rxValid = 1'b1;
        bus.rx      = 8'h02;
        tick();
        bus.rxValid = 1'b0;
        chk("simul_we", 32'(bus.reg_we), 32'(1));
        chk("simul_addr", 32'(bus.reg_addr), 32'(7'h31));
        chk("simul_wdata", 32'(bus.reg_wdata), 32'(8'h02));
        tick();
        chk("simul_active", 32'(bus.frame_active), 32'(0));
        chk("simul_we_drop", 32'(bus.reg_we), 32'(0));
        repeat (4) tick();
        chk("simul_we_count", 32'(q_we.size() - bw), 32'(2));
        ref_mem[7'h30] = 8'h01;
        ref_mem[7'h31] = 8'h02;

        // rxValid with SS high is ignored.
        bw = q_we.size();
        br = q_re.size();
        bus.rxValid = 1'b1;
        bus.rx      = 8'h85;
        tick();
        bus.rxValid = 1'b0;
        repeat (6) tick();
        chk("ss_high_ignored", 32'((q_we.size() - bw) + (q_re.size() - br)), 32'(0));
        chk("ss_high_tx", 32'(bus.tx), 32'(8'hA5));

        // Reset in the middle of a write burst.
        bus.SS = 1'b0;
        repeat (4) tick();
        send_byte(8'h40, 8'hA5, 8'hA5, 1'b0, 1'b0);
        send_byte(8'h01, 8'hA5, 8'hA5, 1'b1, 1'b0);
        ref_mem[7'h40] = 8'h01;
        bus.rxValid = 1'b1;
        bus.rx      = 8'h02;
        tick();
        bus.rxValid = 1'b0;
        chk("midrst_pre_we", 32'(bus.reg_we), 32'(1));
        usrReset = 1'b1;
        #1;
        chk("midrst_we", 32'(bus.reg_we), 32'(0));
        chk("midrst_addr", 32'(bus.reg_addr), 32'(0));
        chk("midrst_wdata", 32'(bus.reg_wdata), 32'(0));
        chk("midrst_tx", 32'(bus.tx), 32'(8'hA5));
        chk("midrst_active", 32'(bus.frame_active), 32'(0));
        chk("midrst_fb", 32'(bus.frame_bytes), 32'(0));
        bw = q_we.size();
        tick();
        tick();
        usrReset = 1'b0;
        repeat (10) tick();
        chk("midrst_no_we", 32'(q_we.size() - bw), 32'(0));
        end_frame();

        // Random frames against the model.
        for (int r = 0; r < 25; r++) begin
            frame_q.delete();
            n = int'($urandom_range(1, 6));
            for (int j = 0; j < n; j++) frame_q.push_back(8'($urandom));
            run_frame(la, lt);
        end

        // 300-byte write frame: counter saturation and address wrap.
        frame_q.delete();
        frame_q.push_back(8'h70);
        for (int j = 1; j < 300; j++) frame_q.push_back(8'(j));
        run_frame(la, lt);
        chk("sat_fb", 32'(bus.frame_bytes), 32'(255));
        chk("sat_last_addr", 32'(la), 32'(7'h1A));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Register-access controller that sequences the SPI byte interface (`spi_slave_byte`) in the `sysClk` domain. It frames the incoming byte stream by slave select and decodes a command byte (read/write flag plus 7-bit address). It then drives a simple single-cycle register bus with auto-incrementing address, and supplies the byte the byte interface shifts out next. It sits between `spi_slave_byte` and the design's control/status register bank.

## Interface
- `IDLE_TX`, 8'hA5: status byte presented on `tx` outside a read burst.
- `sysClk`  in  1  system clock; all logic on rising edge.
- `usrReset`  in  1  asynchronous, active-high reset.
- `SS`  in  1  raw SPI slave select, active low, asynchronous to `sysClk`.
- `rxValid`  in  1  one-cycle strobe from byte interface: `rx` holds a complete byte.
- `rx`  in  8  received byte; valid while `rxValid`.
- `tx`  out  8  byte for the byte interface to shift out next; registered.
- `reg_addr`  out  7  register bus address.
- `reg_wdata`  out  8  register write data.
- `reg_we`  out  1  one-cycle write strobe.
- `reg_re`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  read data; valid exactly one cycle after `reg_re`.
- `frame_active`  out  1  synchronized `SS` is low.
- `frame_bytes`  out  8  bytes received in the current or last frame, saturating at 255.

## Operation
- `SS` passes through a 2-FF synchronizer; `ss_s` denotes the synchronized level.
- Command byte: bit 7 = 1 read, 0 write; bits 6:0 = start address.
- States:
  - IDLE: `ss_s` high. Falling `ss_s` → CMD; `frame_bytes` clears to 0.
  - CMD: first `rxValid` latches the address.
    - Write (bit 7 = 0) → WRITE.
    - Read (bit 7 = 1) → RD_FETCH; issues `reg_re` at the command address.
  - WRITE: each `rxValid` issues `reg_we` with `reg_addr` = current address and `reg_wdata` = `rx`, then increments the address.
  - RD_FETCH: captures `reg_rdata` into `tx`, then → READ.
  - READ: each `rxValid` ignores `rx`, increments the address, issues `reg_re` at the new address, then → RD_FETCH.
- Address is 7-bit modulo: 127 + 1 wraps to 0, in both read and write.
- `tx` = `IDLE_TX` in IDLE, CMD and WRITE.
  - The first byte shifted out in a frame is therefore `IDLE_TX`.
  - The first data byte of a read returns data[addr].
- `frame_bytes` increments on every `rxValid` while `ss_s` is low and saturates at 255. It holds its value after the frame ends.
- Rising `ss_s` in any state → IDLE on the next cycle, and `tx` returns to `IDLE_TX`.
  - An in-flight `reg_re` completes on the bus, but its data is discarded.
  - No `reg_we` is issued after return to IDLE.
- `rxValid` in the same cycle as rising `ss_s`: the byte is processed first (write issued, or read prefetch issued and then discarded), then → IDLE.
- `rxValid` while `ss_s` is high: ignored; `frame_bytes` is unchanged.

## Timing
- Reset values: `tx` = `IDLE_TX`, `reg_addr` = 0, `reg_wdata` = 0, `reg_we` = 0, `reg_re` = 0, `frame_active` = 0, `frame_bytes` = 0. State = IDLE; synchronizer flops are set to 1.
- `SS` falling → `frame_active` high: 3 cycles (2 sync stages + 1 state register).
- `rxValid` at cycle T:
  - Write: `reg_we` high at T+1.
  - Read: `reg_re` high at T+1, `reg_rdata` sampled at T+2, new `tx` stable from T+3.
- System constraint: the first SCLK edge of the next byte occurs at least 4 `sysClk` cycles after `rxValid`. This is met with `sysClk` ≥ 8× SCLK.
- `reg_we` and `reg_re` are never high in the same cycle.
- At most one bus access is issued per `rxValid`.

## Structure
- Package `spi_reg_pkg` holds:
  - the state enum (IDLE, CMD, WRITE, RD_FETCH, READ);
  - `CMD_RD_BIT` = 7;
  - `ADDR_W` = 7;
  - the default `IDLE_TX`.
- One sub-module, `spi_sync2`: a 2-FF synchronizer with async reset to 1, used for `SS`.
- Everything else sits in the top module: FSM, address counter, `tx` register, `frame_bytes` counter.

## Test plan
- Write burst: `SS` low; bytes 0x05, 0x11, 0x22, 0x33 → `reg_we` pulses at addresses 5, 6, 7 with data 0x11, 0x22, 0x33. `tx` stays 0xA5 and `frame_bytes` = 4.
- Read burst: registers 0x7E = 0x3C, 0x7F = 0x4D, 0x00 = 0x5E; command 0xFE followed by 3 dummy bytes.
  - `reg_re` at addresses 7E, 7F, 00, 01, with the address wrapping.
  - `tx` sequence: 0xA5, 0x3C, 0x4D, 0x5E.
  - `tx` updates exactly 3 cycles after each `rxValid`.
- Frame abort: `SS` rises after the read command, with the fetch in progress → IDLE within 3 cycles. `tx` = 0xA5, and a new write frame to address 0x10 behaves normally.
- Simultaneous event: last write byte's `rxValid` in the same cycle as rising `ss_s` → the write is still issued and the state returns to IDLE next cycle. `rxValid` with `SS` high → no bus strobe.
- Reset mid-burst: assert `usrReset` during WRITE → all outputs take their reset values immediately. No `reg_we` follows after release until a new frame and command.
- Saturation: a 300-byte write frame → `frame_bytes` = 255, and the address wraps correctly past 127.
